// File: rtl/matrix_pkg.sv
// Shared types, geometry and address-split helpers for the banked matrix store initiator.
package matrix_pkg;

    localparam int ROW_W     = 10;
    localparam int COL_W     = 10;
    localparam int DATA_W    = 32;
    localparam int NUM_BANKS = 16;
    localparam int ADDR_W    = 16;
    localparam int CNT_W     = 32;
    localparam int BANK_W    = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mpc_state_t;

    typedef struct packed {
        logic              write;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } mat_req_t;

    // The top row bits pick the bank; the remaining row bits and the column form the in-bank address.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [ROW_W-1:0] row);
        return NUM_BANKS'(1) << row[ROW_W-1 -: BANK_W];
    endfunction

    function automatic logic [ADDR_W-1:0] bank_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row[ROW_W-BANK_W-1:0], col};
    endfunction

endpackage

// File: rtl/matrix_port_ctrl_if.sv
// Request/response handshake bundle between the compute engine (master) and the port controller (slave).
interface matrix_port_ctrl_if;
    import matrix_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_row, req_col, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_row, req_col, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/matrix_port_ctrl.sv
// Maps row/col requests onto one-hot bank selects, bank addresses and write strobes,
// and returns captured async read data over a valid/ready response channel.
module matrix_port_ctrl
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_l,
    matrix_port_ctrl_if.slave    bus,
    output logic [NUM_BANKS-1:0] ram_sel,
    output logic [ADDR_W-1:0]    a,
    output logic [DATA_W-1:0]    din,
    output logic [NUM_BANKS-1:0] we,
    input  logic [DATA_W-1:0]    dout,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt
);

    mpc_state_t state;
    logic       is_write;

    assign bus.req_ready = rst_l && (state == IDLE);

    // Bank-side signals are only ever loaded from registers, so the datapath sees no combinational path from req_*.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state         <= IDLE;
            is_write      <= 1'b0;
            ram_sel       <= NUM_BANKS'(1);
            a             <= '0;
            din           <= '0;
            we            <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state    <= ACCESS;
                        is_write <= bus.req_write;
                        ram_sel  <= bank_onehot(bus.req_row);
                        a        <= bank_addr(bus.req_row, bus.req_col);
                        din      <= bus.req_wdata;
                        we       <= bus.req_write ? bank_onehot(bus.req_row) : '0;
                    end
                end
                ACCESS: begin
                    we <= '0;
                    if (is_write) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        state  <= IDLE;
                    end else begin
                        bus.rsp_rdata <= dout;
                        bus.rsp_valid <= 1'b1;
                        rd_cnt        <= rd_cnt + CNT_W'(1);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_port_ctrl.sv
// Bench for matrix_port_ctrl: a row/col-keyed transaction model checked every cycle,
// plus directed literal checks and randomized back-to-back traffic.
module tb_matrix_port_ctrl;
    import matrix_pkg::*;

    logic                 clk;
    logic                 rst_l;
    logic [NUM_BANKS-1:0] ram_sel;
    logic [ADDR_W-1:0]    a;
    logic [DATA_W-1:0]    din;
    logic [NUM_BANKS-1:0] we;
    logic [DATA_W-1:0]    dout;
    logic [CNT_W-1:0]     rd_cnt;
    logic [CNT_W-1:0]     wr_cnt;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;

    matrix_port_ctrl_if bus();

    matrix_port_ctrl dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .bus     (bus),
        .ram_sel (ram_sel),
        .a       (a),
        .din     (din),
        .we      (we),
        .dout    (dout),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Bank RAM environment: async read, write commits at the edge where we is high.
    logic [DATA_W-1:0] ram [int];

    always @(posedge clk) begin
        int bank;
        if (we != '0) begin
            bank = 0;
            for (int i = 0; i < NUM_BANKS; i++) if (we[i]) bank = i;
            ram[bank * 65536 + int'(a)] = din;
            we_cycles++;
        end
    end

    always @(negedge clk) begin
        int bank;
        int key;
        bank = 0;
        for (int i = 0; i < NUM_BANKS; i++) if (ram_sel[i]) bank = i;
        key  = bank * 65536 + int'(a);
        dout = ram.exists(key) ? ram[key] : '0;
    end

    // Transaction-level reference: memory keyed by (row,col), addressing from plain arithmetic.
    logic [DATA_W-1:0]    exp_mem [int];
    bit                   started = 0;
    bit                   m_busy = 0;
    bit                   m_rsp = 0;
    mat_req_t             m_req;
    logic [DATA_W-1:0]    m_rdata = '0;
    logic [CNT_W-1:0]     m_rd = '0;
    logic [CNT_W-1:0]     m_wr = '0;
    logic [NUM_BANKS-1:0] e_sel = 16'h0001;
    logic [ADDR_W-1:0]    e_a = '0;
    logic [DATA_W-1:0]    e_din = '0;
    logic [NUM_BANKS-1:0] e_we = '0;

    function automatic logic [DATA_W-1:0] mem_read(input int key);
        return exp_mem.exists(key) ? exp_mem[key] : '0;
    endfunction

    always @(posedge clk) begin
        int row;
        int col;
        if (!rst_l) begin
            if (m_busy && m_req.write) exp_mem[int'(m_req.row) * 1024 + int'(m_req.col)] = m_req.wdata;
            m_busy  = 0;
            m_rsp   = 0;
            m_rdata = '0;
            m_rd    = '0;
            m_wr    = '0;
            e_sel   = 16'h0001;
            e_a     = '0;
            e_din   = '0;
            e_we    = '0;
        end else if (m_rsp) begin
            if (bus.rsp_ready) m_rsp = 0;
        end else if (m_busy) begin
            m_busy = 0;
            e_we   = '0;
            if (m_req.write) begin
                exp_mem[int'(m_req.row) * 1024 + int'(m_req.col)] = m_req.wdata;
                m_wr = m_wr + 1;
            end else begin
                m_rdata = mem_read(int'(m_req.row) * 1024 + int'(m_req.col));
                m_rd    = m_rd + 1;
                m_rsp   = 1;
            end
        end else if (bus.req_valid) begin
            m_busy        = 1;
            m_req.write   = bus.req_write;
            m_req.row     = bus.req_row;
            m_req.col     = bus.req_col;
            m_req.wdata   = bus.req_wdata;
            row           = int'(bus.req_row);
            col           = int'(bus.req_col);
            e_sel         = 16'(1) << (row / 64);
            e_a           = 16'(((row % 64) * 1024) + col);
            e_din         = bus.req_wdata;
            e_we          = bus.req_write ? e_sel : '0;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("req_ready", bus.req_ready, rst_l && !m_busy && !m_rsp);
            checkOutput("rsp_valid", bus.rsp_valid, m_rsp);
            checkOutput("rsp_rdata", bus.rsp_rdata, m_rdata);
            checkOutput("ram_sel", ram_sel, e_sel);
            checkOutput("a", a, e_a);
            checkOutput("din", din, e_din);
            checkOutput("we", we, e_we);
            checkOutput("we_onehot", ($countones(we) <= 1), 1'b1);
            checkOutput("rd_cnt", rd_cnt, m_rd);
            checkOutput("wr_cnt", wr_cnt, m_wr);
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic applyStimulus(input logic wr, input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                                 input logic [DATA_W-1:0] wdata, input bit hold);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_row   = row;
        bus.req_col   = col;
        bus.req_wdata = wdata;
        while (!bus.req_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("req_accept", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic readReq(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                           input bit rand_ready, input bit hold, output logic [DATA_W-1:0] data);
        int n;
        bit done;
        n    = 0;
        done = 0;
        data = '0;
        applyStimulus(1'b0, row, col, $urandom, hold);
        while (!done && n < 64) begin
            if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
            done = bus.rsp_valid && bus.rsp_ready;
            data = bus.rsp_rdata;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rsp_handshake", done, 1'b1);
        bus.rsp_ready = 1'b1;
    endtask

    logic [ROW_W-1:0]  rows [100];
    logic [COL_W-1:0]  cols [100];
    logic [DATA_W-1:0] rdata;
    int                we_before;

    initial begin
        rst_l         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ram_sel", ram_sel, 16'h0001);
        checkOutput("reset_we", we, 16'h0000);
        checkOutput("reset_req_ready", bus.req_ready, 1'b0);
        rst_l = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_req_ready", bus.req_ready, 1'b1);

        $display("[TB] write/read (0,0)");
        applyStimulus(1'b1, 10'd0, 10'd0, 32'hDEADBEEF, 1'b0);
        checkOutput("t1_ram_sel", ram_sel, 16'h0001);
        checkOutput("t1_a", a, 16'h0000);
        checkOutput("t1_we", we, 16'h0001);
        readReq(10'd0, 10'd0, 1'b0, 1'b0, rdata);
        checkOutput("t1_rdata", rdata, 32'hDEADBEEF);
        checkOutput("t1_wr_cnt", wr_cnt, 32'd1);
        checkOutput("t1_rd_cnt", rd_cnt, 32'd1);

        $display("[TB] corner (1023,1023)");
        we_before = we_cycles;
        applyStimulus(1'b1, 10'd1023, 10'd1023, 32'h12345678, 1'b0);
        checkOutput("t2_ram_sel", ram_sel, 16'h8000);
        checkOutput("t2_a", a, 16'hFFFF);
        checkOutput("t2_we", we, 16'h8000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t2_we_cycles", we_cycles - we_before, 1);
        readReq(10'd1023, 10'd1023, 1'b0, 1'b0, rdata);
        checkOutput("t2_rdata", rdata, 32'h12345678);

        $display("[TB] bank aliasing");
        applyStimulus(1'b1, 10'd64, 10'd5, 32'hA5A5A5A5, 1'b0);
        checkOutput("t3_sel_b1", ram_sel, 16'h0002);
        checkOutput("t3_a_b1", a, 16'h0005);
        applyStimulus(1'b1, 10'd0, 10'd5, 32'h00000000, 1'b0);
        checkOutput("t3_sel_b0", ram_sel, 16'h0001);
        checkOutput("t3_a_b0", a, 16'h0005);
        readReq(10'd64, 10'd5, 1'b0, 1'b0, rdata);
        checkOutput("t3_rdata_b1", rdata, 32'hA5A5A5A5);
        readReq(10'd0, 10'd5, 1'b0, 1'b0, rdata);
        checkOutput("t3_rdata_b0", rdata, 32'h00000000);

        $display("[TB] response backpressure");
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 10'd1023, 10'd1023, 32'h0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_rsp_valid", bus.rsp_valid, 1'b1);
            checkOutput("t4_rdata", bus.rsp_rdata, 32'h12345678);
            checkOutput("t4_req_ready", bus.req_ready, 1'b0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_rsp_done", bus.rsp_valid, 1'b0);
        checkOutput("t4_ready_back", bus.req_ready, 1'b1);

        $display("[TB] reset during response");
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 10'd64, 10'd5, 32'h0, 1'b0);
        @(posedge clk); #1;
        checkOutput("t5_in_resp", bus.rsp_valid, 1'b1);
        rst_l = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("t5_ram_sel", ram_sel, 16'h0001);
        checkOutput("t5_rd_cnt", rd_cnt, 32'd0);
        checkOutput("t5_wr_cnt", wr_cnt, 32'd0);
        checkOutput("t5_req_ready_low", bus.req_ready, 1'b0);
        rst_l = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("t5_req_ready_rel", bus.req_ready, 1'b1);
        @(posedge clk); #1;

        $display("[TB] reset during write access");
        applyStimulus(1'b1, 10'd5, 10'd7, 32'hCAFEF00D, 1'b0);
        rst_l = 1'b0;
        @(posedge clk); #1;
        rst_l = 1'b1;
        checkOutput("t5b_wr_cnt", wr_cnt, 32'd0);
        @(posedge clk); #1;
        readReq(10'd5, 10'd7, 1'b0, 1'b0, rdata);
        checkOutput("t5b_rdata", rdata, 32'hCAFEF00D);

        $display("[TB] random back-to-back traffic");
        for (int i = 0; i < 100; i++) begin
            rows[i] = 10'($urandom_range(0, 1023));
            cols[i] = 10'($urandom_range(0, 1023));
            applyStimulus(1'b1, rows[i], cols[i], $urandom, 1'b1);
        end
        for (int i = 0; i < 100; i++) begin
            readReq(rows[i], cols[i], 1'b1, 1'b1, rdata);
        end
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6_wr_cnt", wr_cnt, 32'd100);
        checkOutput("t6_rd_cnt", rd_cnt, 32'd101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
